// File: rtl/dsp_playback_pkg.sv
// Shared definitions for the DSP playback source: CSR map, ID word, FSM states
// and CTRL/STATUS bit positions.
package dsp_playback_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_LENGTH = 4'd2;
  localparam logic [3:0] ADDR_GAP    = 4'd3;
  localparam logic [3:0] ADDR_WPTR   = 4'd4;
  localparam logic [3:0] ADDR_WDATA  = 4'd5;
  localparam logic [3:0] ADDR_SENT   = 4'd6;
  localparam logic [3:0] ADDR_ID     = 4'd7;

  localparam logic [31:0] ID_VALUE = 32'h504C_4159;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_LOOP  = 2;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_WR_ERR = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dsp_playback_source_if.sv
// CSR slave bus plus streaming source outputs of the playback source.
interface dsp_playback_source_if #(
  parameter int NUM_CH = 8
) ();
  localparam int CH_W = $clog2(NUM_CH);

  logic [3:0]      avs_address;
  logic            avs_read;
  logic            avs_write;
  logic [31:0]     avs_writedata;
  logic [3:0]      avs_byteenable;
  logic [31:0]     avs_readdata;
  logic            avs_readdatavalid;
  logic            avs_waitrequest;
  logic            aso_valid;
  logic [31:0]     aso_data;
  logic [CH_W-1:0] aso_channel;

  // Host / sink side
  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_readdatavalid, avs_waitrequest,
    input  aso_valid, aso_data, aso_channel
  );

  // Playback block side
  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_readdatavalid, avs_waitrequest,
    output aso_valid, aso_data, aso_channel
  );
endinterface

// File: rtl/dsp_playback_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module dsp_playback_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dsp_playback_source.sv
// Test-pattern transmitter: software fills a sample buffer over the CSR bus,
// then a start replays LENGTH samples as a streaming source, one every GAP+1
// cycles, optionally looping. Read pipeline: RAM read -> output register.
module dsp_playback_source
  import dsp_playback_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int NUM_CH = 8,
  parameter int GAP_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dsp_playback_source_if.slave  bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int CH_W = $clog2(NUM_CH);

  state_t            state;
  logic              loop_q, done_q, wr_err_q;
  logic [LW-1:0]     length_q;
  logic [GAP_W-1:0]  gap_q, pace_q;
  logic [AW-1:0]     wptr_q, rd_idx_q;
  logic [31:0]       sent_q;
  logic [CH_W-1:0]   ch_q, aso_channel_q;
  logic              ram_vld_q, aso_valid_q;
  logic [31:0]       aso_data_q, ram_rdata;
  logic [31:0]       rdata_q, rdata_mux;
  logic              rdv_q;
  logic [3:0]        unused_byteenable;

  logic wr_ctrl, wr_status, wr_length, wr_gap, wr_wptr, wr_wdata;
  logic busy, start_req, stop_req, start_go, prot_drop, ram_we;
  logic rd_fire, last_rd, done_set;
  logic [LW-1:0] length_d;

  assign unused_byteenable = bus.avs_byteenable;

  assign wr_ctrl   = bus.avs_write && (bus.avs_address == ADDR_CTRL);
  assign wr_status = bus.avs_write && (bus.avs_address == ADDR_STATUS);
  assign wr_length = bus.avs_write && (bus.avs_address == ADDR_LENGTH);
  assign wr_gap    = bus.avs_write && (bus.avs_address == ADDR_GAP);
  assign wr_wptr   = bus.avs_write && (bus.avs_address == ADDR_WPTR);
  assign wr_wdata  = bus.avs_write && (bus.avs_address == ADDR_WDATA);

  assign busy      = (state == RUN);
  assign start_req = wr_ctrl && bus.avs_writedata[CTRL_START];
  assign stop_req  = wr_ctrl && bus.avs_writedata[CTRL_STOP];
  // stop dominates a simultaneous start; starts while running or with an empty pass are no-ops
  assign start_go  = start_req && !stop_req && !busy && (length_q != '0);
  assign prot_drop = busy && (wr_length || wr_wptr || wr_wdata);
  assign ram_we    = wr_wdata && !busy;

  assign rd_fire   = busy && (pace_q == '0);
  assign last_rd   = rd_fire && ({1'b0, rd_idx_q} == (length_q - LW'(1)));
  assign done_set  = last_rd && !loop_q && !stop_req;

  assign length_d  = (bus.avs_writedata > 32'(DEPTH)) ? LW'(DEPTH)
                                                      : bus.avs_writedata[LW-1:0];

  dsp_playback_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr_q),
    .wdata (bus.avs_writedata),
    .re    (rd_fire),
    .raddr (rd_idx_q),
    .rdata (ram_rdata)
  );

  // Playback sequencer: read index and pace down-counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rd_idx_q <= '0;
      pace_q   <= '0;
    end else if (stop_req) begin
      state <= IDLE;
    end else if (start_go) begin
      state    <= RUN;
      rd_idx_q <= '0;
      pace_q   <= '0;
    end else if (rd_fire) begin
      pace_q <= gap_q;
      if (last_rd) begin
        rd_idx_q <= '0;
        if (!loop_q) state <= IDLE;
      end else begin
        rd_idx_q <= rd_idx_q + AW'(1);
      end
    end else if (busy) begin
      pace_q <= pace_q - GAP_W'(1);
    end
  end

  // CSR-held configuration and sticky status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_q   <= 1'b0;
      length_q <= '0;
      gap_q    <= '0;
      wptr_q   <= '0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      if (wr_ctrl) loop_q <= bus.avs_writedata[CTRL_LOOP];
      if (wr_length && !busy) length_q <= length_d;
      if (wr_gap) gap_q <= bus.avs_writedata[GAP_W-1:0];
      if (wr_wptr && !busy) wptr_q <= bus.avs_writedata[AW-1:0];
      else if (ram_we) wptr_q <= wptr_q + AW'(1);
      if (done_set) done_q <= 1'b1;
      else if (wr_status && bus.avs_writedata[STAT_DONE]) done_q <= 1'b0;
      if (prot_drop) wr_err_q <= 1'b1;
      else if (wr_status && bus.avs_writedata[STAT_WR_ERR]) wr_err_q <= 1'b0;
    end
  end

  // Output stage: sample register, channel rotation and sent counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_vld_q     <= 1'b0;
      aso_valid_q   <= 1'b0;
      aso_data_q    <= '0;
      aso_channel_q <= '0;
      ch_q          <= '0;
      sent_q        <= '0;
    end else begin
      if (stop_req) begin
        ram_vld_q   <= 1'b0;
        aso_valid_q <= 1'b0;
      end else begin
        ram_vld_q   <= rd_fire;
        aso_valid_q <= ram_vld_q;
        if (ram_vld_q) begin
          aso_data_q    <= ram_rdata;
          aso_channel_q <= ch_q;
          ch_q          <= (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
          if (sent_q != 32'hFFFF_FFFF) sent_q <= sent_q + 32'd1;
        end
      end
      if (start_go) begin
        ch_q   <= '0;
        sent_q <= '0;
      end
    end
  end

  always_comb begin
    rdata_mux = 32'd0;
    case (bus.avs_address)
      ADDR_CTRL:   rdata_mux[CTRL_LOOP] = loop_q;
      ADDR_STATUS: rdata_mux = {29'd0, wr_err_q, done_q, busy};
      ADDR_LENGTH: rdata_mux = 32'(length_q);
      ADDR_GAP:    rdata_mux = 32'(gap_q);
      ADDR_WPTR:   rdata_mux = 32'(wptr_q);
      ADDR_SENT:   rdata_mux = sent_q;
      ADDR_ID:     rdata_mux = ID_VALUE;
      default:     rdata_mux = 32'd0;
    endcase
  end

  // Registered CSR read response, one cycle after the strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      rdv_q <= bus.avs_read;
      if (bus.avs_read) rdata_q <= rdata_mux;
    end
  end

  assign bus.avs_readdata      = rdata_q;
  assign bus.avs_readdatavalid = rdv_q;
  assign bus.avs_waitrequest   = 1'b0;
  assign bus.aso_valid         = aso_valid_q;
  assign bus.aso_data          = aso_data_q;
  assign bus.aso_channel       = aso_channel_q;

endmodule

// File: tb/tb_dsp_playback_source.sv
// Directed bench for dsp_playback_source: CSR vector table plus stream sequences.
module tb_dsp_playback_source;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dsp_playback_source_if #(.NUM_CH(8)) bus ();

  dsp_playback_source #(.DEPTH(1024), .NUM_CH(8), .GAP_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  a;
    logic [31:0] d;   // write data, or expected read data
  } csr_vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic [2:0]  ch;
  } smp_t;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int last_cyc = 0;
  smp_t q[$];
  csr_vec_t tbl[$];
  logic [31:0] pat [4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.aso_valid === 1'b1) q.push_back('{cyc, bus.aso_data, bus.aso_channel});

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_writedata = d;
    bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    check($sformatf("rdv_addr%0d", a), 32'(bus.avs_readdatavalid), 32'd1);
    d = bus.avs_readdata;
  endtask

  task automatic read_check(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    csr_read(a, v);
    check(nm, v, exp);
  endtask

  task automatic check_stream(input string nm, input int t0, input int step,
                              input int n, input int len);
    check({nm, "_count"}, 32'(q.size()), 32'(n));
    for (int k = 0; k < n && k < q.size(); k++) begin
      check($sformatf("%s_cyc%0d", nm, k), 32'(q[k].cyc), 32'(t0 + k * step));
      check($sformatf("%s_data%0d", nm, k), q[k].d, pat[k % len]);
      check($sformatf("%s_ch%0d", nm, k), 32'(q[k].ch), 32'(k % 8));
    end
  endtask

  initial begin
    int t0, s0;
    logic [31:0] v;

    pat[0] = 32'h11; pat[1] = 32'h22; pat[2] = 32'h33; pat[3] = 32'h44;
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    bus.avs_writedata = '0; bus.avs_byteenable = 4'hF;

    // Reset state
    idle(3);
    check("rst_valid", 32'(bus.aso_valid), 32'd0);
    check("rst_data", bus.aso_data, 32'd0);
    check("rst_channel", 32'(bus.aso_channel), 32'd0);
    check("rst_readdata", bus.avs_readdata, 32'd0);
    check("rst_rdv", 32'(bus.avs_readdatavalid), 32'd0);
    reset_n = 1'b1;
    idle(2);

    read_check("id", 4'd7, 32'h504C4159);
    idle(1);
    check("rdv_single_cycle", 32'(bus.avs_readdatavalid), 32'd0);

    // CSR vector table
    tbl.push_back('{1'b0, 4'd9,  32'd0});
    tbl.push_back('{1'b0, 4'd0,  32'd0});
    tbl.push_back('{1'b0, 4'd1,  32'd0});
    tbl.push_back('{1'b0, 4'd2,  32'd0});
    tbl.push_back('{1'b0, 4'd3,  32'd0});
    tbl.push_back('{1'b0, 4'd4,  32'd0});
    tbl.push_back('{1'b0, 4'd6,  32'd0});
    tbl.push_back('{1'b1, 4'd2,  32'd5000});
    tbl.push_back('{1'b0, 4'd2,  32'd1024});
    tbl.push_back('{1'b1, 4'd2,  32'd1025});
    tbl.push_back('{1'b0, 4'd2,  32'd1024});
    tbl.push_back('{1'b1, 4'd2,  32'd1023});
    tbl.push_back('{1'b0, 4'd2,  32'd1023});
    tbl.push_back('{1'b1, 4'd2,  32'd4});
    tbl.push_back('{1'b0, 4'd2,  32'd4});
    tbl.push_back('{1'b1, 4'd3,  32'd7});
    tbl.push_back('{1'b0, 4'd3,  32'd7});
    tbl.push_back('{1'b1, 4'd3,  32'd0});
    tbl.push_back('{1'b0, 4'd3,  32'd0});
    tbl.push_back('{1'b1, 4'd0,  32'd4});
    tbl.push_back('{1'b0, 4'd0,  32'd4});
    tbl.push_back('{1'b1, 4'd0,  32'd0});
    tbl.push_back('{1'b0, 4'd0,  32'd0});
    tbl.push_back('{1'b1, 4'd4,  32'd1023});
    tbl.push_back('{1'b1, 4'd5,  32'h55});
    tbl.push_back('{1'b0, 4'd4,  32'd0});
    tbl.push_back('{1'b1, 4'd5,  32'h11});
    tbl.push_back('{1'b1, 4'd5,  32'h22});
    tbl.push_back('{1'b1, 4'd5,  32'h33});
    tbl.push_back('{1'b1, 4'd5,  32'h44});
    tbl.push_back('{1'b0, 4'd4,  32'd4});
    tbl.push_back('{1'b0, 4'd5,  32'd0});
    tbl.push_back('{1'b1, 4'd12, 32'hFFFF_FFFF});
    tbl.push_back('{1'b0, 4'd12, 32'd0});
    tbl.push_back('{1'b0, 4'd15, 32'd0});
    tbl.push_back('{1'b0, 4'd1,  32'd0});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) csr_write(tbl[i].a, tbl[i].d);
      else read_check($sformatf("csr_vec%0d", i), tbl[i].a, tbl[i].d);
    end

    // Basic pass, GAP=0, LENGTH=4
    q.delete();
    csr_write(4'd0, 32'h1);
    t0 = last_cyc;
    read_check("busy_after_start", 4'd1, 32'h1);
    idle(8);
    check_stream("basic", t0 + 2, 1, 4, 4);
    read_check("basic_status", 4'd1, 32'h2);
    read_check("basic_sent", 4'd6, 32'd4);

    // Pacing, GAP=2, LENGTH=3
    csr_write(4'd3, 32'd2);
    csr_write(4'd2, 32'd3);
    q.delete();
    csr_write(4'd0, 32'h1);
    t0 = last_cyc;
    idle(14);
    check_stream("pace", t0 + 2, 3, 3, 3);

    // Loop then stop, LENGTH=2
    csr_write(4'd1, 32'h2);
    read_check("done_w1c", 4'd1, 32'h0);
    csr_write(4'd2, 32'd2);
    csr_write(4'd3, 32'd0);
    q.delete();
    csr_write(4'd0, 32'h5);
    t0 = last_cyc;
    idle(12);
    csr_write(4'd0, 32'h2);
    s0 = last_cyc;
    idle(4);
    check_stream("loop", t0 + 2, 1, s0 - t0 - 2, 2);
    read_check("stop_status", 4'd1, 32'h0);
    read_check("stop_sent", 4'd6, 32'(s0 - t0 - 2));

    // Busy-write protection
    csr_write(4'd4, 32'd0);
    csr_write(4'd0, 32'h5);
    idle(3);
    csr_write(4'd5, 32'hDEAD);
    csr_write(4'd0, 32'h2);
    read_check("wr_err_set", 4'd1, 32'h4);
    read_check("wptr_held", 4'd4, 32'd0);
    csr_write(4'd0, 32'h0);
    idle(2);
    q.delete();
    csr_write(4'd0, 32'h1);
    t0 = last_cyc;
    idle(8);
    check_stream("after_busy_wr", t0 + 2, 1, 2, 2);
    read_check("done_and_err", 4'd1, 32'h6);
    csr_write(4'd1, 32'h4);
    read_check("wr_err_w1c", 4'd1, 32'h2);

    // Ignored starts
    csr_write(4'd1, 32'h6);
    csr_write(4'd2, 32'd0);
    q.delete();
    csr_write(4'd0, 32'h1);
    read_check("len0_busy", 4'd1, 32'h0);
    idle(6);
    check("len0_no_valid", 32'(q.size()), 32'd0);
    csr_write(4'd2, 32'd2);
    csr_write(4'd0, 32'h3);
    read_check("startstop_busy", 4'd1, 32'h0);
    idle(6);
    check("startstop_no_valid", 32'(q.size()), 32'd0);
    csr_write(4'd2, 32'd4);
    csr_write(4'd3, 32'd3);
    csr_write(4'd0, 32'h1);
    t0 = last_cyc;
    idle(4);
    csr_write(4'd0, 32'h1);
    idle(20);
    check_stream("restart_ignored", t0 + 2, 4, 4, 4);
    read_check("restart_sent", 4'd6, 32'd4);
    read_check("restart_status", 4'd1, 32'h2);

    // Reset mid-run
    csr_write(4'd2, 32'd2);
    csr_write(4'd3, 32'd0);
    csr_write(4'd0, 32'h5);
    idle(3);
    reset_n = 1'b0;
    idle(1);
    check("midrst_valid", 32'(bus.aso_valid), 32'd0);
    check("midrst_data", bus.aso_data, 32'd0);
    check("midrst_channel", 32'(bus.aso_channel), 32'd0);
    check("midrst_rdv", 32'(bus.avs_readdatavalid), 32'd0);
    reset_n = 1'b1;
    idle(1);
    q.delete();
    read_check("midrst_status", 4'd1, 32'h0);
    read_check("midrst_ctrl", 4'd0, 32'h0);
    read_check("midrst_length", 4'd2, 32'h0);
    read_check("midrst_wptr", 4'd4, 32'h0);
    read_check("midrst_sent", 4'd6, 32'h0);
    idle(4);
    check("midrst_no_valid", 32'(q.size()), 32'd0);
    v = 32'd0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
